// File: rtl/proc_multicycle.sv
// proc_multicycle: N-bit multicycle processor with R0..R7, accumulator A, result G, zero flag and a 4-state control FSM
//   P_clock, reset (async, active-high) | Run, DIN[N-1:0] in | Done, BusWires[N-1:0], R0_out, R1_out, Zflag out
module proc_multicycle #(
  parameter int N = 16
) (
  input  logic         P_clock,
  input  logic         reset,
  input  logic         Run,
  input  logic [N-1:0] DIN,
  output logic         Done,
  output logic [N-1:0] BusWires,
  output logic [N-1:0] R0_out,
  output logic [N-1:0] R1_out,
  output logic         Zflag
);
  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;
  state_t state, next;
  logic [N-1:0] r [8];
  logic [N-1:0] a, g, res;
  logic [8:0] ir;
  logic [2:0] op, x, y;
  logic alu, rx_en, a_en, g_en;
  assign op = ir[8:6];
  assign x = ir[5:3];
  assign y = ir[2:0];
  assign alu = op == 3'd2 || op == 3'd3 || op == 3'd5;
  assign res = op == 3'd2 ? a + BusWires : op == 3'd3 ? a - BusWires : a & BusWires;
  assign R0_out = r[0];
  assign R1_out = r[1];
  always_comb begin
    next = state;
    Done = 1'b0;
    BusWires = '0;
    rx_en = 1'b0;
    a_en = 1'b0;
    g_en = 1'b0;
    case (state)
      T0: next = Run ? T1 : T0;
      T1: begin
        next = alu ? T2 : T0;
        Done = !alu;
        a_en = alu;
        // NOPs (11x) drive an idle bus
        BusWires = alu ? r[x] : op == 3'd1 ? DIN : op[2:1] == 2'b11 ? '0 : r[y];
        rx_en = op == 3'd0 || op == 3'd1 || (op == 3'd4 && !Zflag);
      end
      T2: begin
        next = T3;
        BusWires = r[y];
        g_en = 1'b1;
      end
      T3: begin
        next = T0;
        BusWires = g;
        rx_en = 1'b1;
        Done = 1'b1;
      end
      default: next = T0;
    endcase
  end
  always_ff @(posedge P_clock or posedge reset) begin
    if (reset) begin
      state <= T0;
      ir <= '0;
      a <= '0;
      g <= '0;
      Zflag <= 1'b1;
      for (int i = 0; i < 8; i++) r[i] <= '0;
    end else begin
      state <= next;
      if (state == T0 && Run) ir <= DIN[8:0];
      if (a_en) a <= BusWires;
      if (g_en) begin
        g <= res;
        Zflag <= res == '0;
      end
      if (rx_en) r[x] <= BusWires;
    end
  end
endmodule

// File: tb/tb_proc_multicycle.sv
// tb_proc_multicycle: randomized instruction stream checked every cycle against an instruction-level model
module tb_proc_multicycle;
  localparam int N = 16;
  logic P_clock = 1'b0, reset = 1'b1, Run = 1'b0;
  logic [N-1:0] DIN = '0;
  logic Done, Zflag;
  logic [N-1:0] BusWires, R0_out, R1_out;
  logic [N-1:0] m [8];
  logic mz, exp_done;
  logic [N-1:0] exp_bus;
  bit chk_en = 1'b0;
  int errors = 0, checks = 0;

  proc_multicycle #(.N(N)) dut (
    .P_clock(P_clock), .reset(reset), .Run(Run), .DIN(DIN), .Done(Done),
    .BusWires(BusWires), .R0_out(R0_out), .R1_out(R1_out), .Zflag(Zflag)
  );

  always #5 P_clock = ~P_clock;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge P_clock) if (chk_en) begin
    chk("Done", N'(Done), N'(exp_done));
    chk("BusWires", BusWires, exp_bus);
    chk("R0_out", R0_out, m[0]);
    chk("R1_out", R1_out, m[1]);
    chk("Zflag", N'(Zflag), N'(mz));
  end

  task automatic tick();
    @(posedge P_clock);
    #1;
  endtask

  task automatic mreset();
    for (int i = 0; i < 8; i++) m[i] = '0;
    mz = 1'b1;
    exp_done = 1'b0;
    exp_bus = '0;
  endtask

  task automatic idle(input int n);
    Run = 1'b0;
    DIN = N'($urandom);
    exp_done = 1'b0;
    exp_bus = '0;
    repeat (n) tick();
  endtask

  task automatic exec(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y, input logic [N-1:0] imm);
    logic alu;
    logic [N-1:0] res;
    alu = op == 3'd2 || op == 3'd3 || op == 3'd5;
    Run = 1'b1;
    DIN = N'($urandom);
    DIN[8:0] = {op, x, y};
    exp_done = 1'b0;
    exp_bus = '0;
    tick();
    Run = 1'($urandom);
    DIN = op == 3'd1 ? imm : N'($urandom);
    if (!alu) begin
      exp_done = 1'b1;
      exp_bus = op == 3'd1 ? imm : op >= 3'd6 ? '0 : m[y];
      tick();
      if (op == 3'd0 || op == 3'd1 || (op == 3'd4 && !mz)) m[x] = exp_bus;
    end else begin
      exp_bus = m[x];
      tick();
      Run = 1'b1;
      DIN = N'($urandom);
      exp_bus = m[y];
      res = op == 3'd2 ? m[x] + m[y] : op == 3'd3 ? m[x] - m[y] : m[x] & m[y];
      tick();
      mz = res == '0;
      Run = 1'($urandom);
      DIN = N'($urandom);
      exp_bus = res;
      exp_done = 1'b1;
      tick();
      m[x] = res;
    end
    Run = 1'b0;
    exp_done = 1'b0;
    exp_bus = '0;
  endtask

  initial begin
    mreset();
    chk_en = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exec(3'd1, 3'd0, 3'd0, 16'h0005);
    chk("mvi R0 literal", R0_out, 16'h0005);
    exec(3'd1, 3'd1, 3'd0, 16'h0003);
    exec(3'd2, 3'd0, 3'd1, '0);
    chk("add R0 literal", R0_out, 16'h0008);
    chk("add Z literal", N'(Zflag), N'(1'b0));
    exec(3'd3, 3'd1, 3'd1, '0);
    chk("sub R1,R1 literal", R1_out, 16'h0000);
    chk("sub Z literal", N'(Zflag), N'(1'b1));
    exec(3'd4, 3'd2, 3'd0, '0);
    chk("mvnz blocked model", m[2], 16'h0000);
    exec(3'd1, 3'd3, 3'd0, 16'h0001);
    exec(3'd3, 3'd0, 3'd3, '0);
    chk("sub R0,R3 Z literal", N'(Zflag), N'(1'b0));
    exec(3'd4, 3'd2, 3'd0, '0);
    exec(3'd0, 3'd1, 3'd2, '0);
    chk("mvnz taken literal", R1_out, 16'h0007);
    exec(3'd1, 3'd4, 3'd0, 16'hFFFF);
    exec(3'd1, 3'd5, 3'd0, 16'h0001);
    exec(3'd2, 3'd4, 3'd5, '0);
    chk("wrap add Z literal", N'(Zflag), N'(1'b1));
    exec(3'd0, 3'd0, 3'd4, '0);
    chk("wrap add literal", R0_out, 16'h0000);
    exec(3'd3, 3'd4, 3'd5, '0);
    exec(3'd0, 3'd1, 3'd4, '0);
    chk("wrap sub literal", R1_out, 16'hFFFF);
    exec(3'd1, 3'd2, 3'd0, 16'h1234);
    exec(3'd2, 3'd2, 3'd2, '0);
    exec(3'd0, 3'd0, 3'd2, '0);
    chk("double literal", R0_out, 16'h2468);
    exec(3'd6, 3'd0, 3'd0, '0);
    chk("nop model", m[0], 16'h2468);
    idle(2);
    Run = 1'b1;
    DIN = 16'h0081;
    tick();
    Run = 1'b0;
    exp_bus = m[0];
    tick();
    exp_bus = m[1];
    @(negedge P_clock);
    #1;
    reset = 1'b1;
    mreset();
    #1;
    chk("reset abort R0", R0_out, 16'h0000);
    chk("reset abort Done", N'(Done), N'(1'b0));
    tick();
    reset = 1'b0;
    idle(1);
    exec(3'd0, 3'd6, 3'd0, '0);
    exec(3'd0, 3'd1, 3'd6, '0);
    chk("mv after reset literal", R1_out, 16'h0000);
    for (int i = 0; i < 400; i++) begin
      exec(3'($urandom), 3'($urandom), 3'($urandom), N'($urandom_range(0, 3) == 0 ? 0 : $urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(1);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
